// File: rtl/filter_stream_ctrl_if.sv
// Stream-side bundle for filter_stream_ctrl: upstream samples, the filter
// START/DATA handshake, and the downstream result channel.
interface filter_stream_ctrl_if #(
  parameter int BITWIDTH_DATA = 12
);
  logic [BITWIDTH_DATA-1:0] s_data;
  logic                     s_valid;
  logic                     s_ready;
  logic                     filt_start;
  logic [BITWIDTH_DATA-1:0] filt_data;
  logic                     filt_valid;
  logic [BITWIDTH_DATA-1:0] filt_result;
  logic [BITWIDTH_DATA-1:0] m_data;
  logic                     m_valid;
  logic                     m_ready;

  // controller side
  modport master (
    input  s_data, s_valid, filt_valid, filt_result, m_ready,
    output s_ready, filt_start, filt_data, m_data, m_valid
  );

  // source, filter and sink side
  modport slave (
    output s_data, s_valid, filt_valid, filt_result, m_ready,
    input  s_ready, filt_start, filt_data, m_data, m_valid
  );
endinterface

// File: rtl/filter_stream_ctrl.sv
// Upstream controller for the single-multiplier FIR family: buffers samples in a
// FIFO, feeds the filter one sample at a time and forwards each result downstream.
module filter_stream_ctrl #(
  parameter int BITWIDTH_DATA  = 12,
  parameter int FIFO_DEPTH     = 8,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        en,
  filter_stream_ctrl_if.master        bus,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output logic                        err_timeout
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_WAIT_ACK,
    S_WAIT_DONE,
    S_OUTPUT
  } state_t;

  state_t                   state;
  logic [BITWIDTH_DATA-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]         wr_ptr;
  logic [PTR_W-1:0]         rd_ptr;
  logic [LVL_W-1:0]         level;
  logic [TMO_W-1:0]         tmo_cnt;
  logic                     filt_start_q;
  logic [BITWIDTH_DATA-1:0] filt_data_q;
  logic [BITWIDTH_DATA-1:0] m_data_q;
  logic                     m_valid_q;
  logic                     full;
  logic                     empty;
  logic                     ready;
  logic                     push;
  logic                     launch;
  logic                     timeout_hit;

  assign full        = (level == LVL_W'(FIFO_DEPTH));
  assign empty       = (level == '0);
  // Reset is folded in so the source sees not-ready for the whole reset window.
  assign ready       = en && !rst && !full;
  assign push        = bus.s_valid && ready;
  assign launch      = en && (state == S_IDLE) && !empty && bus.filt_valid;
  assign timeout_hit = (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));

  assign bus.s_ready    = ready;
  assign bus.filt_start = filt_start_q;
  assign bus.filt_data  = filt_data_q;
  assign bus.m_data     = m_data_q;
  assign bus.m_valid    = m_valid_q;
  assign fifo_level     = level;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= bus.s_data;
    end
  end

  // FIFO bookkeeping; a pop only ever happens on launch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (launch) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, launch})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_IDLE;
      filt_start_q <= 1'b0;
      filt_data_q  <= '0;
      m_data_q     <= '0;
      m_valid_q    <= 1'b0;
      err_timeout  <= 1'b0;
      tmo_cnt      <= '0;
    end else if (!en) begin
      // Any in-flight sample is abandoned; the filter resets through its own EN.
      state        <= S_IDLE;
      filt_start_q <= 1'b0;
      m_valid_q    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (launch) begin
            filt_data_q  <= mem[rd_ptr];
            filt_start_q <= 1'b1;
            tmo_cnt      <= '0;
            state        <= S_START;
          end
        end
        S_START: begin
          filt_start_q <= 1'b0;
          state        <= S_WAIT_ACK;
        end
        S_WAIT_ACK: begin
          tmo_cnt <= tmo_cnt + TMO_W'(1);
          if (!bus.filt_valid) begin
            state <= S_WAIT_DONE;
          end else if (timeout_hit) begin
            err_timeout <= 1'b1;
            state       <= S_IDLE;
          end
        end
        S_WAIT_DONE: begin
          tmo_cnt <= tmo_cnt + TMO_W'(1);
          if (bus.filt_valid) begin
            m_data_q  <= bus.filt_result;
            m_valid_q <= 1'b1;
            state     <= S_OUTPUT;
          end else if (timeout_hit) begin
            err_timeout <= 1'b1;
            state       <= S_IDLE;
          end
        end
        S_OUTPUT: begin
          if (bus.m_ready) begin
            m_valid_q <= 1'b0;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_filter_stream_ctrl.sv
// Directed bench for filter_stream_ctrl with a behavioural LENGTH=4 filter that
// returns input+1, and a scoreboard of expected downstream results.
module tb_filter_stream_ctrl;

  localparam int W      = 12;
  localparam int DEPTH  = 8;
  localparam int TMO    = 16;
  localparam int LENGTH = 4;

  logic                       clk;
  logic                       rst;
  logic                       en;
  logic [$clog2(DEPTH):0]     fifo_level;
  logic                       err_timeout;

  filter_stream_ctrl_if #(.BITWIDTH_DATA(W)) bus ();

  filter_stream_ctrl #(
    .BITWIDTH_DATA (W),
    .FIFO_DEPTH    (DEPTH),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .bus        (bus),
    .fifo_level (fifo_level),
    .err_timeout(err_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          cyc = 0;
  int          errors = 0;
  int          checks = 0;
  int          starts = 0;
  int          results = 0;
  int          last_push = 0;
  logic [W-1:0] exp_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Behavioural filter: DATA_VALID low from the edge that sees START through
  // PREP and LENGTH calc cycles; `stuck` makes it ignore START entirely.
  bit           stuck = 1'b0;
  logic         fv;
  logic [W-1:0] fres;
  logic [W-1:0] flat;
  int           fcnt;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      fv <= 1'b1; fres <= '0; flat <= '0; fcnt <= 0;
    end else if (!en) begin
      fv <= 1'b1; fcnt <= 0;
    end else if (bus.filt_start && !stuck) begin
      fv <= 1'b0; flat <= bus.filt_data; fcnt <= LENGTH + 1;
    end else if (fcnt > 0) begin
      fcnt <= fcnt - 1;
      if (fcnt == 1) begin
        fv   <= 1'b1;
        fres <= flat + W'(1);
      end
    end
  end

  assign bus.filt_valid  = fv;
  assign bus.filt_result = fres;

  // Starts and accepted results are observed on the falling edge.
  always @(negedge clk) begin
    if (bus.filt_start === 1'b1) starts++;
    if (bus.m_valid === 1'b1 && bus.m_ready === 1'b1) begin
      results++;
      if (exp_q.size() == 0) check("unexpected_result", 32'(bus.m_data), 32'hFFFF_FFFF);
      else check("result", 32'(bus.m_data), 32'(exp_q.pop_front()));
    end
  end

  task automatic wait_until(input int c);
    for (int i = 0; i < 100000 && cyc < c; i++) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic push(input logic [W-1:0] d, input bit want);
    bit ok = 1'b0;
    bus.s_data  = d;
    bus.s_valid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus.s_ready === 1'b1) begin ok = 1'b1; break; end
    end
    @(posedge clk); #1;
    bus.s_valid = 1'b0;
    last_push   = cyc;
    if (!ok) check("push_ready_timeout", 32'(bus.s_ready), 32'd1);
    else if (want) exp_q.push_back(d + W'(1));
  endtask

  task automatic drain();
    for (int i = 0; i < 600; i++) begin
      if (exp_q.size() == 0 && bus.m_valid !== 1'b1) break;
      @(posedge clk); #1;
    end
    check("drain_empty", 32'(exp_q.size()), 32'd0);
    repeat (3) @(posedge clk);
    #1;
  endtask

  int k;
  int st0;
  int r0;

  initial begin
    rst = 1'b1; en = 1'b1; stuck = 1'b0;
    bus.s_data = '0; bus.s_valid = 1'b0; bus.m_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_s_ready",    32'(bus.s_ready),    32'd0);
    check("rst_filt_start", 32'(bus.filt_start), 32'd0);
    check("rst_filt_data",  32'(bus.filt_data),  32'd0);
    check("rst_m_data",     32'(bus.m_data),     32'd0);
    check("rst_m_valid",    32'(bus.m_valid),    32'd0);
    check("rst_fifo_level", 32'(fifo_level),     32'd0);
    check("rst_err",        32'(err_timeout),    32'd0);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Single sample latency
    push(12'h123, 1'b1);
    k = last_push;
    wait_until(k + 1); check("single_start_hi", 32'(bus.filt_start), 32'd1);
    check("single_filt_data", 32'(bus.filt_data), 32'h123);
    wait_until(k + 2); check("single_start_lo", 32'(bus.filt_start), 32'd0);
    wait_until(k + 7); check("single_mvalid_early", 32'(bus.m_valid), 32'd0);
    wait_until(k + 8); check("single_mvalid", 32'(bus.m_valid), 32'd1);
    check("single_mdata", 32'(bus.m_data), 32'h124);
    bus.m_ready = 1'b1;
    drain();

    // Burst with backpressure
    bus.m_ready = 1'b0;
    st0 = starts; r0 = results;
    for (int i = 0; i < 9; i++) begin
      push(W'(12'h100 + i), 1'b1);
      if (i == 0) k = last_push;
    end
    check("burst_level_full", 32'(fifo_level), 32'd8);
    check("burst_s_ready_lo", 32'(bus.s_ready), 32'd0);
    check("burst_one_start", 32'(starts - st0), 32'd1);
    wait_until(k + 12);
    check("burst_hold_valid", 32'(bus.m_valid), 32'd1);
    check("burst_hold_data", 32'(bus.m_data), 32'h101);
    bus.s_data = 12'h109; bus.s_valid = 1'b1;
    wait_until(k + 20);
    check("burst_hold_valid2", 32'(bus.m_valid), 32'd1);
    check("burst_hold_data2", 32'(bus.m_data), 32'h101);
    check("burst_level_blocked", 32'(fifo_level), 32'd8);
    check("burst_one_start2", 32'(starts - st0), 32'd1);
    bus.m_ready = 1'b1;
    push(12'h109, 1'b1);
    drain();
    check("burst_count", 32'(results - r0), 32'd10);

    // Push coinciding with launch at level 1
    bus.m_ready = 1'b0;
    st0 = starts;
    push(12'h200, 1'b1);
    k = last_push;
    push(12'h300, 1'b1);
    check("simul_level", 32'(fifo_level), 32'd1);
    check("simul_start", 32'(bus.filt_start), 32'd1);
    wait_until(k + 12);
    check("simul_held", 32'(bus.m_valid), 32'd1);
    check("simul_no_2nd_start", 32'(starts - st0), 32'd1);
    bus.m_ready = 1'b1;
    wait_until(k + 13);
    check("simul_accepted", 32'(bus.m_valid), 32'd0);
    check("simul_no_early_start", 32'(bus.filt_start), 32'd0);
    wait_until(k + 14);
    check("simul_next_start", 32'(bus.filt_start), 32'd1);
    check("simul_next_data", 32'(bus.filt_data), 32'h300);
    drain();

    // Filter never acknowledges
    stuck = 1'b1;
    r0 = results;
    push(12'h0AA, 1'b0);
    k = last_push;
    push(12'h0BB, 1'b1);
    wait_until(k + 17); check("tmo_err_early", 32'(err_timeout), 32'd0);
    wait_until(k + 18); check("tmo_err", 32'(err_timeout), 32'd1);
    check("tmo_no_mvalid", 32'(bus.m_valid), 32'd0);
    stuck = 1'b0;
    wait_until(k + 19); check("tmo_next_start", 32'(bus.filt_start), 32'd1);
    check("tmo_next_data", 32'(bus.filt_data), 32'h0BB);
    drain();
    check("tmo_results", 32'(results - r0), 32'd1);

    // EN drop during WAIT_DONE
    push(12'h011, 1'b0);
    k = last_push;
    push(12'h022, 1'b1);
    push(12'h033, 1'b1);
    wait_until(k + 4);
    en = 1'b0;
    #1;
    check("en_s_ready", 32'(bus.s_ready), 32'd0);
    wait_until(k + 5);
    check("en_mvalid", 32'(bus.m_valid), 32'd0);
    check("en_filt_start", 32'(bus.filt_start), 32'd0);
    check("en_level", 32'(fifo_level), 32'd2);
    check("en_err_kept", 32'(err_timeout), 32'd1);
    st0 = starts;
    wait_until(k + 10);
    check("en_level_held", 32'(fifo_level), 32'd2);
    check("en_no_start", 32'(starts - st0), 32'd0);
    en = 1'b1;
    wait_until(k + 11);
    check("en_restart", 32'(bus.filt_start), 32'd1);
    check("en_restart_data", 32'(bus.filt_data), 32'h022);
    check("en_restart_level", 32'(fifo_level), 32'd1);
    drain();

    // Asynchronous reset mid-sample
    bus.m_ready = 1'b0;
    push(12'h155, 1'b1);
    k = last_push;
    push(12'h166, 1'b1);
    wait_until(k + 5);
    rst = 1'b1;
    #1;
    check("arst_s_ready",    32'(bus.s_ready),    32'd0);
    check("arst_filt_start", 32'(bus.filt_start), 32'd0);
    check("arst_filt_data",  32'(bus.filt_data),  32'd0);
    check("arst_m_data",     32'(bus.m_data),     32'd0);
    check("arst_m_valid",    32'(bus.m_valid),    32'd0);
    check("arst_level",      32'(fifo_level),     32'd0);
    check("arst_err",        32'(err_timeout),    32'd0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    st0 = starts;
    wait_until(cyc + 10);
    check("post_rst_level", 32'(fifo_level), 32'd0);
    check("post_rst_no_start", 32'(starts - st0), 32'd0);
    check("post_rst_mvalid", 32'(bus.m_valid), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
